// File: rtl/conv_encoder_punct.sv
// 802.11a K=7 convolutional encoder with 1/2, 2/3 and 3/4 puncturing on AXI4-Stream.
// Define CONV_ENC_SKID_EN for a 2-entry output skid buffer with a registered s_axis_tready.
module conv_encoder_punct #(
  parameter int         WIDTH = 24,
  parameter logic [6:0] G0    = 7'o133,
  parameter logic [6:0] G1    = 7'o171
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic [WIDTH-1:0]   s_axis_tdata,
  input  logic [3:0]         s_axis_tuser,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  input  logic               s_axis_tlast,
  output logic [2*WIDTH-1:0] m_axis_tdata,
  output logic [1:0]         m_axis_tuser,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic               m_axis_tlast
);

  if (WIDTH % 6 != 0) begin : g_width_check
    $error("conv_encoder_punct: WIDTH must be a multiple of 6");
  end

  // SIGNAL-field RATE codes (R1 in the MSB)
  localparam logic [3:0] RATE_6M  = 4'b1101;
  localparam logic [3:0] RATE_9M  = 4'b1111;
  localparam logic [3:0] RATE_12M = 4'b0101;
  localparam logic [3:0] RATE_18M = 4'b0111;
  localparam logic [3:0] RATE_24M = 4'b1001;
  localparam logic [3:0] RATE_36M = 4'b1011;
  localparam logic [3:0] RATE_48M = 4'b0001;
  localparam logic [3:0] RATE_54M = 4'b0011;

  localparam logic [1:0] CODE_R12 = 2'd0;
  localparam logic [1:0] CODE_R23 = 2'd1;
  localparam logic [1:0] CODE_R34 = 2'd2;

  typedef struct packed {
    logic [2*WIDTH-1:0] data;
    logic [1:0]         user;
    logic               last;
  } beat_t;

  logic [5:0]         state;
  logic [5:0]         enc_state;
  logic [6:0]         taps;
  logic [WIDTH-1:0]   bit_a;
  logic [WIDTH-1:0]   bit_b;
  logic [1:0]         rate_code;
  logic [2*WIDTH-1:0] punct;
  logic               accept;
  beat_t              enc_beat;

  assign accept = s_axis_tvalid && s_axis_tready;

  // NOTE: blocking assignments are correct here: enc_state is a combinational
  // running value that each loop iteration must see updated immediately.
  always_comb begin
    enc_state = state;
    taps      = '0;
    bit_a     = '0;
    bit_b     = '0;
    for (int i = 0; i < WIDTH; i++) begin
      taps      = {s_axis_tdata[i], enc_state};
      bit_a[i]  = ^(taps & G0);
      bit_b[i]  = ^(taps & G1);
      enc_state = {s_axis_tdata[i], enc_state[5:1]};
    end
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    rate_code = CODE_R12;
    case (s_axis_tuser)
      RATE_6M, RATE_12M, RATE_24M:          rate_code = CODE_R12;
      RATE_48M:                             rate_code = CODE_R23;
      RATE_9M, RATE_18M, RATE_36M, RATE_54M: rate_code = CODE_R34;
      default:                              rate_code = CODE_R12;
    endcase
  end

  // Every beat holds whole puncture periods, so the pattern restarts at bit 0.
  always_comb begin
    punct = '0;
    case (rate_code)
      CODE_R23: begin
        for (int p = 0; p < WIDTH / 2; p++) begin
          punct[3*p]   = bit_a[2*p];
          punct[3*p+1] = bit_b[2*p];
          punct[3*p+2] = bit_a[2*p+1];
        end
      end
      CODE_R34: begin
        for (int p = 0; p < WIDTH / 3; p++) begin
          punct[4*p]   = bit_a[3*p];
          punct[4*p+1] = bit_b[3*p];
          punct[4*p+2] = bit_a[3*p+1];
          punct[4*p+3] = bit_b[3*p+2];
        end
      end
      default: begin
        for (int i = 0; i < WIDTH; i++) begin
          punct[2*i]   = bit_a[i];
          punct[2*i+1] = bit_b[i];
        end
      end
    endcase
  end

  assign enc_beat = '{data: punct, user: rate_code, last: s_axis_tlast};

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= '0;
    end else if (accept) begin
      state <= s_axis_tlast ? 6'd0 : enc_state;
    end
  end

`ifdef CONV_ENC_SKID_EN
  beat_t      skid [2];
  logic [1:0] count;
  logic       full;
  logic       pop;

  assign pop = (count != 2'd0) && m_axis_tready;

  // NOTE: the skid entries are reset explicitly because they drive the outputs
  // directly and must read as 0 after reset.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      skid[0] <= '0;
      skid[1] <= '0;
      count   <= 2'd0;
      full    <= 1'b0;
    end else begin
      case ({accept, pop})
        2'b10: begin
          if (count == 2'd0) skid[0] <= enc_beat;
          else               skid[1] <= enc_beat;
          count <= count + 2'd1;
          full  <= (count == 2'd1);
        end
        2'b01: begin
          skid[0] <= skid[1];
          count   <= count - 2'd1;
          full    <= 1'b0;
        end
        2'b11: begin
          if (count == 2'd1) begin
            skid[0] <= enc_beat;
          end else begin
            skid[0] <= skid[1];
            skid[1] <= enc_beat;
          end
        end
        default: ;
      endcase
    end
  end

  assign s_axis_tready = !full;
  assign m_axis_tvalid = (count != 2'd0);
  assign m_axis_tdata  = skid[0].data;
  assign m_axis_tuser  = skid[0].user;
  assign m_axis_tlast  = skid[0].last;
`else
  beat_t out_q;
  logic  out_v;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      out_q <= '0;
      out_v <= 1'b0;
    end else if (accept) begin
      out_q <= enc_beat;
      out_v <= 1'b1;
    end else if (m_axis_tready) begin
      out_v <= 1'b0;
    end
  end

  assign s_axis_tready = !out_v || m_axis_tready;
  assign m_axis_tvalid = out_v;
  assign m_axis_tdata  = out_q.data;
  assign m_axis_tuser  = out_q.user;
  assign m_axis_tlast  = out_q.last;
`endif

endmodule
